seq_mul8: RTL and testbench
===========================

# seq_mul8

Sequential 8×8 unsigned shift-add multiplier producing a 16-bit product. It sits directly upstream of the 16-bit carry-lookahead adder and feeds it operands every cycle: the running partial product and the shifted multiplicand. It consumes the adder's combinational sum in the same cycle and registers it. Operand intake and product delivery use valid/ready handshakes.

## Interface
- No parameters; widths fixed (8-bit operands, 16-bit adder path).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept operands.
- `in_a`  in  8  multiplicand, unsigned.
- `in_b`  in  8  multiplier, unsigned.
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  consumer accepts product.
- `out_prod`  out  16  product `in_a*in_b`.
- `add_a`  out  16  adder operand A = accumulator register.
- `add_b`  out  16  adder operand B = gated, shifted multiplicand.
- `add_s`  in  16  adder sum, combinational from `add_a`/`add_b` in the same cycle.

## Operation
- Registers:
  - `acc[15:0]`
  - `mcand[15:0]`: zero-extended `in_a`, shifted left 1 per RUN edge.
  - `mplier[7:0]`: `in_b`, shifted right 1 per RUN edge.
  - `cnt[2:0]`
  - `state`
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`: load `mcand`={8'h0,`in_a`}, `mplier`=`in_b`, `acc`=0, `cnt`=0, go to RUN.
  - RUN:
    - `add_a`=`acc`; `add_b`=`mplier[0]` ? `mcand` : 16'h0.
    - Each edge: `acc`<=`add_s`, `mcand`<<=1, `mplier`>>=1, `cnt`++.
    - At the edge where `cnt`==7: go to DONE.
  - DONE: `out_valid`=1, `out_prod`=`acc` (held stable). On `out_ready`: go to IDLE. Exception: with `in_valid` also high, load the new operands and go directly to RUN.
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`).
- Outside RUN, `add_a`=`acc` and `add_b`=0. The adder output is ignored outside RUN.
- Arithmetic rules:
  - Max `add_b` is 0x7F80 (bit 7 shifted 7); max product is 0xFE01.
  - The 16-bit sum never overflows, so no carry-out is used.
- Boundary conditions:
  - `in_valid` high outside IDLE/DONE-handoff: ignored, not latched.
  - `out_ready` high outside DONE: no effect.
  - Operands are sampled only at the accept edge; later changes to `in_a`/`in_b` have no effect.
  - `rst` mid-RUN or in DONE: abandons the operation, no product emitted.

## Timing
- Reset values: state=IDLE, `acc`=0, `mcand`=0, `mplier`=0, `cnt`=0.
- Outputs after reset: `in_ready`=1, `out_valid`=0, `out_prod`=0, `add_a`=0, `add_b`=0.
- Accept edge E0; RUN edges E1..E8; `out_valid` high from the cycle after E8. Latency: 8 edges from accept to `out_valid`, early termination off.
- `out_valid` stays high until the edge where `out_ready`=1.
- Back-to-back throughput: one product per 9 cycles. Handoff edge E0' coincides with the product-accept edge.
- Combinational paths:
  - `add_a`/`add_b` depend only on registers.
  - `add_s`→`acc` is the only path through the external adder; it must close in one cycle.

## Configuration
- `SEQ_MUL_EARLY_TERM_EN` defined:
  - A RUN edge also transitions to DONE when the post-shift `mplier` is zero.
  - Minimum 1 RUN edge: multiplier 0x00 or 0x01 yields `out_valid` 1 edge after accept.
  - Multiplier 0x80 still takes 8 edges.
- Not defined: RUN always lasts exactly 8 edges. The product value is identical in both builds.

## Test plan
- Reset, then `in_a`=0x03, `in_b`=0x05, `out_ready`=1 → `out_prod`=0x000F, `out_valid` high exactly 8 edges after accept (macro off); 1-cycle pulse.
- `in_a`=0xFF, `in_b`=0xFF → 0xFE01. `add_b` sequence over RUN is 0x00FF, 0x01FE, …, 0x7F80.
- `in_a`=0xAB, `in_b`=0x00, `out_ready`=0 for 5 cycles → `out_prod`=0x0000 held with `out_valid`=1 and `in_ready`=0 until `out_ready`; latency 1 edge if `SEQ_MUL_EARLY_TERM_EN`, 8 if not.
- Back-to-back: hold `in_valid`=1 and `out_ready`=1 with pairs (0x12,0x34),(0x56,0x78) → products 0x03A8, 0x2850; second accept on the same edge as first product accept; 9-cycle spacing.
- Assert `rst` for 1 cycle at RUN edge E4 with (0x0F,0x0F) → IDLE next cycle, `in_ready`=1, `out_valid` never rises for that operation; new op (0x02,0x02) → 0x0004.
- Random 1000 pairs with random `in_valid`/`out_ready` stalls → every product equals `in_a*in_b`, in order, none dropped or duplicated.

Source files
------------

// File: rtl/seq_mul8.sv
// -----------------------------------------------------------------------------
// seq_mul8 -- sequential 8x8 unsigned shift-add multiplier, 16-bit product.
//
// The accumulation adder is external. Every RUN cycle this block presents the
// running partial product on add_a and the gated, shifted multiplicand on
// add_b, then registers the combinational sum add_s on the next rising edge.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   operand pair valid
//   in_ready   out  1   block can accept operands (IDLE, or DONE being drained)
//   in_a       in   8   multiplicand, unsigned
//   in_b       in   8   multiplier, unsigned
//   out_valid  out  1   product valid (held until out_ready)
//   out_ready  in   1   consumer accepts product
//   out_prod   out  16  product in_a*in_b
//   add_a      out  16  adder operand A = accumulator
//   add_b      out  16  adder operand B = mplier[0] ? mcand : 0 (RUN only)
//   add_s      in   16  adder sum, combinational from add_a/add_b
//
// Configuration
//   SEQ_MUL_EARLY_TERM_EN  when defined, RUN also ends on the edge where the
//                          shifted multiplier becomes zero (minimum one RUN
//                          edge). Undefined: RUN always lasts 8 edges.
// -----------------------------------------------------------------------------
module seq_mul8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_prod,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    input  logic [15:0] add_s
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [15:0] acc_r;
    logic [15:0] mcand_r;
    logic [7:0]  mplier_r;
    logic [2:0]  cnt_r;
    logic        out_valid_r;
    logic        run_last_s;

    // Decide whether the current RUN edge is the final one.
    always_comb begin
        run_last_s = 1'b0;
`ifdef SEQ_MUL_EARLY_TERM_EN
        // Post-shift multiplier is zero when only bit 0 (or nothing) remains.
        if ((cnt_r == 3'd7) || (mplier_r[7:1] == 7'd0)) begin
            run_last_s = 1'b1;
        end else begin
            run_last_s = 1'b0;
        end
`else
        if (cnt_r == 3'd7) begin
            run_last_s = 1'b1;
        end else begin
            run_last_s = 1'b0;
        end
`endif
    end

    // Adder operands and the input handshake, all derived from registers
    // except the DONE-handoff term of in_ready.
    always_comb begin
        add_a    = acc_r;
        add_b    = 16'h0000;
        in_ready = 1'b0;
        if ((state_r == ST_RUN) && mplier_r[0]) begin
            add_b = mcand_r;
        end else begin
            add_b = 16'h0000;
        end
        if (state_r == ST_IDLE) begin
            in_ready = 1'b1;
        end else if (state_r == ST_DONE) begin
            in_ready = out_ready;
        end else begin
            in_ready = 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign out_prod  = acc_r;

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            acc_r       <= 16'h0000;
            mcand_r     <= 16'h0000;
            mplier_r    <= 8'h00;
            cnt_r       <= 3'd0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc_r    <= 16'h0000;
                        mcand_r  <= {8'h00, in_a};
                        mplier_r <= in_b;
                        cnt_r    <= 3'd0;
                        state_r  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_r    <= add_s;
                    mcand_r  <= {mcand_r[14:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[7:1]};
                    cnt_r    <= cnt_r + 3'd1;
                    if (run_last_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        // Product handed off; a waiting operand pair starts
                        // on the same edge so back-to-back ops cost 9 cycles.
                        if (in_valid) begin
                            acc_r    <= 16'h0000;
                            mcand_r  <= {8'h00, in_a};
                            mplier_r <= in_b;
                            cnt_r    <= 3'd0;
                            state_r  <= ST_RUN;
                        end else begin
                            state_r  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul8.sv
// -----------------------------------------------------------------------------
// tb_seq_mul8 -- scoreboard bench for seq_mul8. The external adder is modelled
// here as a plain 16-bit add. Stimulus pushes the expected product when an
// operand pair is accepted; a monitor process pops and compares whenever a
// product is handed off.
// -----------------------------------------------------------------------------
module tb_seq_mul8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prod;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] add_s;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_products = 0;
    logic [15:0] sb[$];

    localparam int N_RAND = 1000;
    localparam int LAT_80 = 8;
`ifdef SEQ_MUL_EARLY_TERM_EN
    localparam int LAT_35 = 3;
    localparam int LAT_00 = 1;
`else
    localparam int LAT_35 = 8;
    localparam int LAT_00 = 8;
`endif

    seq_mul8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s)
    );

    assign add_s = add_a + add_b;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired, event did not occur", name);
    endtask

    // Monitor: compares every handed-off product against the scoreboard head.
    task automatic monitor();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_product: got 0x%0h, expected none", out_prod);
                end else begin
                    e = sb.pop_front();
                    check("product", {16'h0000, out_prod}, {16'h0000, e});
                    n_products++;
                end
            end
        end
    endtask

    // Present an operand pair, push its expected product on acceptance and
    // return just after the accept edge. keep leaves in_valid asserted.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                         input bit keep, output int acc_cyc);
        bit ok;
        ok = 1'b0;
        acc_cyc = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_bound("accept");
        end else begin
            sb.push_back(exp);
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            in_valid = 1'b0;
            in_a = 8'($urandom);
            in_b = 8'($urandom);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) fail_bound("out_valid");
    endtask

    task automatic wait_drain(input int bound);
        int i;
        i = 0;
        while (sb.size() != 0 && i < bound) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (sb.size() != 0) fail_bound("drain");
    endtask

    initial begin
        int c1;
        int c2;
        int lat;
        int np;
        int sent;
        bit acc_flag;
        bit seen;
        logic [15:0] ab_tab [8];
        ab_tab = '{16'h00FF, 16'h01FE, 16'h03FC, 16'h07F8,
                   16'h0FF0, 16'h1FE0, 16'h3FC0, 16'h7F80};

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        out_ready = 1'b0;
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_prod", {16'h0, out_prod}, 32'h0);
        check("rst_add_a", {16'h0, add_a}, 32'h0);
        check("rst_add_b", {16'h0, add_b}, 32'h0);

        // 3 x 5, latency and single-cycle valid pulse
        out_ready = 1'b1;
        issue(8'h03, 8'h05, 16'h000F, 1'b0, c1);
        wait_valid(lat);
        check("lat_3x5", lat, LAT_35);
        @(posedge clk);
        #1;
        check("pulse_3x5", {31'h0, out_valid}, 32'h0);

        // 0xFF x 0xFF, adder operand B sequence over RUN
        issue(8'hFF, 8'hFF, 16'hFE01, 1'b0, c1);
        check("add_a_run0", {16'h0, add_a}, 32'h0);
        for (int k = 0; k < 8; k++) begin
            check("add_b_seq", {16'h0, add_b}, {16'h0, ab_tab[k]});
            @(posedge clk);
            #1;
        end
        check("valid_ffxff", {31'h0, out_valid}, 32'h1);
        wait_drain(20);

        // 0xAB x 0x00 with consumer stalled; new operands must be ignored
        out_ready = 1'b0;
        issue(8'hAB, 8'h00, 16'h0000, 1'b0, c1);
        wait_valid(lat);
        check("lat_abx00", lat, LAT_00);
        in_a = 8'h11;
        in_b = 8'h22;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", {31'h0, out_valid}, 32'h1);
            check("stall_in_ready", {31'h0, in_ready}, 32'h0);
            check("stall_prod", {16'h0, out_prod}, 32'h0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain(20);
        check("stall_released", {31'h0, out_valid}, 32'h0);

        // Multiplier 0x80 always takes 8 edges
        issue(8'h02, 8'h80, 16'h0100, 1'b0, c1);
        wait_valid(lat);
        check("lat_x80", lat, LAT_80);
        wait_drain(20);

        // Back-to-back handoff
        np = n_products;
        issue(8'h12, 8'h34, 16'h03A8, 1'b1, c1);
        issue(8'h56, 8'h78, 16'h2850, 1'b0, c2);
        check("b2b_spacing", c2 - c1, 32'd9);
        check("b2b_first_out", n_products, np + 1);
        wait_drain(30);

        // Reset at RUN edge E4 abandons the operation
        issue(8'h0F, 8'h0F, 16'h00E1, 1'b0, c1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_back());
        check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_prod", {16'h0, out_prod}, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", {31'h0, seen}, 32'h0);
        issue(8'h02, 8'h02, 16'h0004, 1'b0, c1);
        wait_drain(20);

        // Random pairs with random stalls on both sides
        sent = 0;
        acc_flag = 1'b0;
        for (int c = 0; c < 40000 && sent < N_RAND; c++) begin
            @(posedge clk);
            #1;
            if (acc_flag) begin
                in_valid = 1'b0;
                acc_flag = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid) begin
                in_a = 8'($urandom);
                in_b = 8'($urandom);
                in_valid = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back({8'h00, in_a} * {8'h00, in_b});
                sent++;
                acc_flag = 1'b1;
            end
        end
        if (sent != N_RAND) fail_bound("random_issue");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain(200);

        check("sb_empty", sb.size(), 32'd0);
        check("product_count", n_products, 7 + N_RAND);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
